// File: rtl/mem_sync_ctrl_pkg.sv
// Shared definitions for the DM->IM write-tracking sync controller.
// Holds the sync FSM encoding and the legal DM read-latency window.
package mem_sync_ctrl_pkg;

  typedef enum logic [1:0] {
    SYNC_IDLE  = 2'd0,
    SYNC_DRAIN = 2'd1,
    SYNC_FLUSH = 2'd2
  } sync_state_e;

  localparam int READ_LAT_MIN = 1;
  localparam int READ_LAT_MAX = 4;

  // Out-of-range latencies are pulled into the supported window.
  function automatic int clampReadLat(input int lat);
    if (lat < READ_LAT_MIN) return READ_LAT_MIN;
    if (lat > READ_LAT_MAX) return READ_LAT_MAX;
    return lat;
  endfunction

endpackage

// File: rtl/mem_sync_ctrl_if.sv
// Core-facing and SPRAM-facing bus of the sync controller.
// The controller uses the slave modport; the core/memory side uses master.
interface mem_sync_ctrl_if #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32
);

  logic              i_dm_wen;
  logic [ADDR_W-1:0] i_dm_addr;
  logic              i_fence_i;
  logic [DATA_W-1:0] i_dm_rdata;
  logic              o_sync_active;
  logic              o_sync_dm_ren;
  logic [ADDR_W-1:0] o_sync_dm_addr;
  logic              o_im_wen;
  logic [ADDR_W-1:0] o_im_addr;
  logic [DATA_W-1:0] o_im_wdata;
  logic              o_ready;
  logic              o_fence_done;
  logic              o_overflow;

  modport slave (
    input  i_dm_wen, i_dm_addr, i_fence_i, i_dm_rdata,
    output o_sync_active, o_sync_dm_ren, o_sync_dm_addr,
    output o_im_wen, o_im_addr, o_im_wdata,
    output o_ready, o_fence_done, o_overflow
  );

  modport master (
    output i_dm_wen, i_dm_addr, i_fence_i, i_dm_rdata,
    input  o_sync_active, o_sync_dm_ren, o_sync_dm_addr,
    input  o_im_wen, o_im_addr, o_im_wdata,
    input  o_ready, o_fence_done, o_overflow
  );

endinterface

// File: rtl/mem_sync_ctrl_sync_addr_fifo.sv
// Circular buffer of dirty DM word addresses awaiting copy into IM.
// An extra count bit separates full from empty so every slot is usable.
module sync_addr_fifo #(
  parameter int ADDR_W     = 14,
  parameter int DEPTH_LOG2 = 8
) (
  input  logic                clk,
  input  logic                i_rst,
  input  logic                push_i,
  input  logic                pop_i,
  input  logic [ADDR_W-1:0]   data_i,
  output logic [ADDR_W-1:0]   data_o,
  output logic [DEPTH_LOG2:0] count_o,
  output logic                full_o,
  output logic                empty_o
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = 1;
  localparam logic [DEPTH_LOG2:0]   CNT_ONE = 1;

  logic [ADDR_W-1:0]     mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] head_q;
  logic [DEPTH_LOG2-1:0] tail_q;
  logic [DEPTH_LOG2:0]   count_q;
  logic                  doPush;
  logic                  doPop;

  assign full_o  = count_q[DEPTH_LOG2];
  assign empty_o = (count_q == '0);
  assign doPush  = push_i && !full_o;
  assign doPop   = pop_i && !empty_o;
  assign data_o  = mem_q[head_q];
  assign count_o = count_q;

  always_ff @(posedge clk) begin
    if (doPush) mem_q[tail_q] <= data_i;
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (doPush) tail_q <= tail_q + PTR_ONE;
      if (doPop) head_q <= head_q + PTR_ONE;
      if (doPush && !doPop) count_q <= count_q + CNT_ONE;
      else if (doPop && !doPush) count_q <= count_q - CNT_ONE;
    end
  end

endmodule

// File: rtl/mem_sync_ctrl.sv
// Tracks DM writes and, on fence.i or a full tracker, copies each dirty
// word from DM into IM through a READ_LAT-deep read pipeline.
module mem_sync_ctrl
  import mem_sync_ctrl_pkg::*;
#(
  parameter int ADDR_W     = 14,
  parameter int DATA_W     = 32,
  parameter int DEPTH_LOG2 = 8,
  parameter int READ_LAT   = 1,
  parameter bit AUTO_DRAIN = 1'b1
) (
  input logic            clk,
  input logic            i_rst,
  mem_sync_ctrl_if.slave bus
);

  localparam int LAT = clampReadLat(READ_LAT);
  localparam logic [DEPTH_LOG2:0] CNT_ONE = 1;

  sync_state_e         state_q;
  logic                fencePending_q;
  logic                fenceDone_q;
  logic                overflow_q;
  logic                imWen_q;
  logic [ADDR_W-1:0]   imAddr_q;
  logic [DATA_W-1:0]   imWdata_q;
  logic [LAT-1:0]      pipeVld_q;
  logic [ADDR_W-1:0]   pipeAddr_q [LAT];

  logic                ready;
  logic                push;
  logic                pop;
  logic                startDrain;
  logic                fifoFull;
  logic                fifoEmpty;
  logic [ADDR_W-1:0]   headAddr;
  logic [DEPTH_LOG2:0] fifoCount;

  assign ready      = (state_q == SYNC_IDLE) && !fifoFull;
  assign push       = bus.i_dm_wen && ready;
  assign pop        = (state_q == SYNC_DRAIN) && !fifoEmpty;
  assign startDrain = bus.i_fence_i || (AUTO_DRAIN && fifoFull);

  sync_addr_fifo #(
    .ADDR_W     (ADDR_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk     (clk),
    .i_rst   (i_rst),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (bus.i_dm_addr),
    .data_o  (headAddr),
    .count_o (fifoCount),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty)
  );

  always_ff @(posedge clk) begin
    if (i_rst) begin
      pipeVld_q <= '0;
    end else begin
      pipeVld_q[0] <= pop;
      for (int i = 1; i < LAT; i++) pipeVld_q[i] <= pipeVld_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    pipeAddr_q[0] <= headAddr;
    for (int i = 1; i < LAT; i++) pipeAddr_q[i] <= pipeAddr_q[i-1];
  end

  // A fence on an empty tracker is acknowledged without leaving IDLE.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      state_q        <= SYNC_IDLE;
      fencePending_q <= 1'b0;
      fenceDone_q    <= 1'b0;
      overflow_q     <= 1'b0;
      imWen_q        <= 1'b0;
      imAddr_q       <= '0;
      imWdata_q      <= '0;
    end else begin
      fenceDone_q <= 1'b0;
      imWen_q     <= pipeVld_q[LAT-1];
      imAddr_q    <= pipeAddr_q[LAT-1];
      imWdata_q   <= bus.i_dm_rdata;
      if (bus.i_dm_wen && !ready) overflow_q <= 1'b1;
      case (state_q)
        SYNC_IDLE: begin
          if (startDrain) begin
            if (!fifoEmpty || push) begin
              state_q        <= SYNC_DRAIN;
              fencePending_q <= bus.i_fence_i;
            end else begin
              fenceDone_q <= bus.i_fence_i;
            end
          end
        end
        SYNC_DRAIN: begin
          if (fifoCount == CNT_ONE) state_q <= SYNC_FLUSH;
        end
        SYNC_FLUSH: begin
          if (pipeVld_q == '0) begin
            state_q        <= SYNC_IDLE;
            fenceDone_q    <= fencePending_q;
            fencePending_q <= 1'b0;
          end
        end
        default: state_q <= SYNC_IDLE;
      endcase
    end
  end

  assign bus.o_sync_active  = (state_q != SYNC_IDLE) || (|pipeVld_q);
  assign bus.o_sync_dm_ren  = pop;
  assign bus.o_sync_dm_addr = headAddr;
  assign bus.o_im_wen       = imWen_q;
  assign bus.o_im_addr      = imAddr_q;
  assign bus.o_im_wdata     = imWdata_q;
  assign bus.o_ready        = ready;
  assign bus.o_fence_done   = fenceDone_q;
  assign bus.o_overflow     = overflow_q;

endmodule

// File: tb/tb_mem_sync_ctrl.sv
// Bench for mem_sync_ctrl: two configurations share one stimulus stream and
// each is scored against a transaction-level model of the sync timing rules.
module tb_mem_sync_ctrl;

  typedef struct {
    int          cyc;
    logic [13:0] addr;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        dmWen = 1'b0;
  logic [13:0] dmAddr = '0;
  logic        fence = 1'b0;
  logic        endCheck = 1'b0;
  int          cyc = 0;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] dmData(input logic [13:0] a);
    return {a[7:0], ~a[7:0], 2'b10, a};
  endfunction

  task automatic checkOutput(input string name, input int dut,
                             input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL dut%0d %s: got 0x%0h, expected 0x%0h (cycle %0d)",
               dut, name, act, exp, cyc);
    end
  endtask

  task automatic applyStimulus(input logic wen, input logic [13:0] addr,
                               input logic fen, input logic r);
    @(negedge clk);
    dmWen  = wen;
    dmAddr = addr;
    fence  = fen;
    rst    = r;
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int DL    = (g == 0) ? 2 : 4;
    localparam int RL    = (g == 0) ? 1 : 3;
    localparam bit AUTO  = (g == 0);
    localparam int DEPTH = 1 << DL;

    mem_sync_ctrl_if #(.ADDR_W(14), .DATA_W(32)) bus ();

    assign bus.i_dm_wen  = dmWen;
    assign bus.i_dm_addr = dmAddr;
    assign bus.i_fence_i = fence;

    mem_sync_ctrl #(
      .ADDR_W     (14),
      .DATA_W     (32),
      .DEPTH_LOG2 (DL),
      .READ_LAT   (RL),
      .AUTO_DRAIN (AUTO)
    ) dut (
      .clk   (clk),
      .i_rst (rst),
      .bus   (bus)
    );

    logic [13:0] dirty [$];
    ev_t         expRd [$];
    ev_t         expIm [$];
    int          expDone [$];
    int          readyFrom = 0;
    logic        ovf = 1'b0;
    logic [13:0] addrHist [8];
    bit          endDone = 1'b0;

    // Reference model: tracker contents plus the cycles at which each
    // drain's reads, IM writes and completion are due.
    always @(posedge clk) begin : model
      int  c;
      int  n;
      bit  idle;
      bit  full;
      bit  rdy;
      c = cyc;
      if (rst) begin
        dirty.delete();
        expRd.delete();
        expIm.delete();
        expDone.delete();
        readyFrom = 0;
        ovf = 1'b0;
      end else begin
        idle = (c >= readyFrom);
        full = (dirty.size() == DEPTH);
        rdy  = idle && !full;
        if (dmWen && !rdy) ovf = 1'b1;
        if (dmWen && rdy) dirty.push_back(dmAddr);
        if (idle && (fence || (AUTO && full))) begin
          n = dirty.size();
          if (n == 0) begin
            expDone.push_back(c + 1);
          end else begin
            for (int i = 0; i < n; i++) begin
              expRd.push_back('{c + 1 + i, dirty[i]});
              expIm.push_back('{c + 2 + RL + i, dirty[i]});
            end
            if (fence) expDone.push_back(c + n + 2 + RL);
            readyFrom = c + n + 2 + RL;
            dirty.delete();
          end
        end
      end
    end

    // DM responder and scoreboard monitor.
    always @(negedge clk) begin : monitor
      int c;
      c = cyc;
      addrHist[c % 8] = bus.o_sync_dm_addr;
      bus.i_dm_rdata = dmData(addrHist[(c - RL + 8) % 8]);
      if (c > 0) begin
        checkOutput("ready", g, bus.o_ready,
                    (c >= readyFrom) && (dirty.size() < DEPTH));
        checkOutput("overflow", g, bus.o_overflow, ovf);
        checkOutput("sync_active", g, bus.o_sync_active, c < readyFrom);

        if (bus.o_sync_dm_ren) begin
          if (expRd.size() > 0 && expRd[0].cyc == c) begin
            checkOutput("dm_read_addr", g, bus.o_sync_dm_addr, expRd[0].addr);
            void'(expRd.pop_front());
          end else begin
            checkOutput("dm_read_spurious", g, 1, 0);
          end
        end else if (expRd.size() > 0 && expRd[0].cyc <= c) begin
          checkOutput("dm_read_missing", g, 0, 1);
          void'(expRd.pop_front());
        end

        if (bus.o_im_wen) begin
          if (expIm.size() > 0 && expIm[0].cyc == c) begin
            checkOutput("im_addr", g, bus.o_im_addr, expIm[0].addr);
            checkOutput("im_wdata", g, bus.o_im_wdata, dmData(expIm[0].addr));
            void'(expIm.pop_front());
          end else begin
            checkOutput("im_wen_spurious", g, 1, 0);
          end
        end else if (expIm.size() > 0 && expIm[0].cyc <= c) begin
          checkOutput("im_wen_missing", g, 0, 1);
          void'(expIm.pop_front());
        end

        if (bus.o_fence_done) begin
          if (expDone.size() > 0 && expDone[0] == c) begin
            checkOutput("fence_done", g, 1, 1);
            void'(expDone.pop_front());
          end else begin
            checkOutput("fence_done_spurious", g, 1, 0);
          end
        end else if (expDone.size() > 0 && expDone[0] <= c) begin
          checkOutput("fence_done_missing", g, 0, 1);
          void'(expDone.pop_front());
        end

        if (endCheck && !endDone) begin
          endDone = 1'b1;
          checkOutput("pending_at_end", g,
                      expRd.size() + expIm.size() + expDone.size(), 0);
        end
      end
    end
  end

  initial begin
    // Reset, then three writes and a fence
    repeat (3) applyStimulus(1'b0, 14'h0000, 1'b0, 1'b1);
    applyStimulus(1'b0, 14'h0000, 1'b0, 1'b0);
    applyStimulus(1'b1, 14'h0010, 1'b0, 1'b0);
    applyStimulus(1'b1, 14'h0020, 1'b0, 1'b0);
    applyStimulus(1'b1, 14'h0030, 1'b0, 1'b0);
    applyStimulus(1'b0, 14'h0000, 1'b1, 1'b0);
    repeat (12) applyStimulus(1'b0, 14'h0000, 1'b0, 1'b0);

    // Fence with nothing tracked
    applyStimulus(1'b0, 14'h0000, 1'b1, 1'b0);
    repeat (4) applyStimulus(1'b0, 14'h0000, 1'b0, 1'b0);

    // Fill the small tracker, then one write too many
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 14'(16'h0100 + i), 1'b0, 1'b0);
    repeat (15) applyStimulus(1'b0, 14'h0000, 1'b0, 1'b0);

    // Write and fence in the same cycle
    applyStimulus(1'b1, 14'h0040, 1'b1, 1'b0);
    repeat (20) applyStimulus(1'b0, 14'h0000, 1'b0, 1'b0);
    applyStimulus(1'b0, 14'h0000, 1'b0, 1'b1);

    // Reset two cycles into a four-entry drain
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 14'(16'h0200 + i), 1'b0, 1'b0);
    applyStimulus(1'b0, 14'h0000, 1'b1, 1'b0);
    applyStimulus(1'b0, 14'h0000, 1'b0, 1'b0);
    applyStimulus(1'b0, 14'h0000, 1'b0, 1'b1);
    repeat (6) applyStimulus(1'b0, 14'h0000, 1'b0, 1'b0);

    // Randomised traffic
    for (int i = 0; i < 600; i++) begin
      applyStimulus($urandom_range(99) < 40, 14'($urandom),
                    $urandom_range(99) < 4, $urandom_range(249) == 0);
    end

    repeat (80) applyStimulus(1'b0, 14'h0000, 1'b0, 1'b0);
    endCheck = 1'b1;
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
